seg7_capture: RTL

- Receive-side counterpart of the hex-to-7-segment encoder.
- Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit strobes).
- Debounces each digit's pattern, decodes it back to a hex nibble, and assembles a full multi-digit word.
- Presents the word with a valid/ready handshake; used for display loop-back checking and on-board self-test of the processor's hex outputs.

---
 rtl/seg7_capture_if.sv | 21 ++
 rtl/seg7_capture.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seg7_capture_if.sv
// Output handshake bundle for seg7_capture: assembled word, error flag, valid/ready.
// overrun_out exists only when SEG7_CAP_OVERRUN_EN is defined.
interface seg7_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic                    err_out;
`ifdef SEG7_CAP_OVERRUN_EN
  logic                    overrun_out;

  modport master (output out_valid, output value_out, output err_out, output overrun_out,
                  input out_ready);
  modport slave  (input out_valid, input value_out, input err_out, input overrun_out,
                  output out_ready);
`else
  modport master (output out_valid, output value_out, output err_out, input out_ready);
  modport slave  (input out_valid, input value_out, input err_out, output out_ready);
`endif
endinterface

// File: rtl/seg7_capture.sv
// Captures a multiplexed active-low 7-seg bus into a hex word; 2+STABLE_CYCLES clocks pins->capture.
// Word held with out_valid until out_ready; optional SEG7_CAP_OVERRUN_EN flags captures dropped meanwhile.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  seg7_capture_if.master        out_if
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t                       state, state_nxt;
  logic [6:0]                   seg_s1, seg_s2, seg_p;
  logic [NUM_DIGITS-1:0]        sel_s1, sel_s2, sel_p;
  logic [7:0]                   cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0]        seen, seen_cap, bad, bad_cap;
  logic [NUM_DIGITS-1:0][3:0]   nib, nib_cap;
  logic [4*NUM_DIGITS-1:0]      val_q;
  logic                         vld_q, err_q;
  logic                         same, cap, ill, go, hs;
  logic [3:0]                   dnib;

  // Returns {illegal, nibble}; table is active-low in g..a bit order.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  assign same    = (seg_s2 == seg_p) && (sel_s2 == sel_p);
  assign cnt_nxt = !same ? 8'd1 : ((cnt == STABLE) ? cnt : cnt + 8'd1);
  // Fires only on the step into saturation, so a held pattern captures once.
  assign cap     = same && (cnt == STABLE - 8'd1) && $onehot(sel_s2);
  assign {ill, dnib} = decode(seg_s2);

  always_comb begin
    state_nxt = state;
    seen_cap  = seen;
    bad_cap   = bad;
    nib_cap   = nib;
    go        = 1'b0;
    hs        = 1'b0;
    case (state)
      COLLECT: begin
        if (cap) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_s2[i]) begin
              seen_cap[i] = 1'b1;
              bad_cap[i]  = ill;
              nib_cap[i]  = dnib;
            end
          end
        end
        if (&seen_cap) begin
          state_nxt = PRESENT;
          go        = 1'b1;
        end
      end
      PRESENT: begin
        if (vld_q && out_if.out_ready) begin
          state_nxt = COLLECT;
          hs        = 1'b1;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= 7'h7F;
      seg_s2 <= 7'h7F;
      seg_p  <= 7'h7F;
      sel_s1 <= '0;
      sel_s2 <= '0;
      sel_p  <= '0;
      cnt    <= '0;
      state  <= COLLECT;
      seen   <= '0;
      bad    <= '0;
      nib    <= '0;
      val_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
      sel_s1 <= dig_sel;
      sel_s2 <= sel_s1;
      sel_p  <= sel_s2;
      cnt    <= cnt_nxt;
      state  <= state_nxt;
      nib    <= nib_cap;
      seen   <= hs ? '0 : seen_cap;
      bad    <= hs ? '0 : bad_cap;
      if (go) begin
        val_q <= nib_cap;
        err_q <= |bad_cap;
        vld_q <= 1'b1;
      end else if (hs) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign out_if.out_valid = vld_q;
  assign out_if.value_out = val_q;
  assign out_if.err_out   = err_q;

`ifdef SEG7_CAP_OVERRUN_EN
  logic overrun;

  // Set wins over the handshake clear so a coincident capture is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         overrun <= 1'b0;
    else if (state == PRESENT && cap)   overrun <= 1'b1;
    else if (hs)                        overrun <= 1'b0;
  end

  assign out_if.overrun_out = overrun;
`endif

endmodule
